uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART TX FIFO write port between NumReq requesters,
// with a stall timeout that releases a requester that stops supplying data mid-packet.
module uart_tx_arbiter #(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned DataLength    = 8,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NumReq-1:0]            i_req_valid,
    input  logic [NumReq*DataLength-1:0] i_req_data,
    input  logic [NumReq-1:0]            i_req_last,
    output logic [NumReq-1:0]            o_req_ready,
    output logic [DataLength-1:0]        o_tx_data,
    output logic                         o_tx_req,
    input  logic                         i_tx_rdy,
    output logic [NumReq-1:0]            o_grant,
    output logic                         o_busy,
    output logic                         o_timeout,
    output logic [$clog2(NumReq)-1:0]    o_timeout_id
);

    localparam int unsigned IdW  = $clog2(NumReq);
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
    localparam logic [IdW-1:0]  IdLast  = IdW'(NumReq - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  gid_q, gid_d;
    logic [IdW-1:0]  last_id_q, last_id_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic [IdW-1:0]  timeout_id_q, timeout_id_d;

    logic [DataLength-1:0] req_bytes [NumReq];
    logic [IdW-1:0]        pick;
    logic                  found;
    int unsigned           idx;
    logic                  busy;
    logic                  xfer;

    always_comb begin
        for (int k = 0; k < int'(NumReq); k++) begin
            req_bytes[k] = i_req_data[k*DataLength +: DataLength];
        end
    end

    // Circular search starting just above the previous owner.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= NumReq; i++) begin
            idx = (int'(last_id_q) + i) % NumReq;
            if (!found && i_req_valid[IdW'(idx)]) begin
                found = 1'b1;
                pick  = IdW'(idx);
            end
        end
    end

    assign busy = (state_q == StGrant);
    assign xfer = busy & i_req_valid[gid_q] & i_tx_rdy;

    always_comb begin
        o_req_ready = '0;
        o_tx_data   = '0;
        o_grant     = '0;
        if (busy) begin
            o_req_ready[gid_q] = i_tx_rdy;
            o_tx_data          = req_bytes[gid_q];
            o_grant[gid_q]     = 1'b1;
        end
    end

    assign o_tx_req     = xfer;
    assign o_busy       = busy;
    assign o_timeout    = timeout_q;
    assign o_timeout_id = timeout_id_q;

    always_comb begin
        state_d      = state_q;
        gid_d        = gid_q;
        last_id_d    = last_id_q;
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StGrant;
                    gid_d   = pick;
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (i_req_last[gid_q]) begin
                        state_d   = StIdle;
                        last_id_d = gid_q;
                    end
                end else if (TimeoutCycles != 0 && cnt_q == CntLast) begin
                    // Partial packet is left as sent; the owner simply loses the port.
                    state_d      = StIdle;
                    last_id_d    = gid_q;
                    timeout_d    = 1'b1;
                    timeout_id_d = gid_q;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            gid_q        <= '0;
            last_id_q    <= IdLast;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            state_q      <= state_d;
            gid_q        <= gid_d;
            last_id_q    <= last_id_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic, all compared
// cycle by cycle against a behavioural model of owner / round-robin / stall-count rules.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    typedef struct {
        int         gap;
        bit         last;
        logic [7:0] data;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   vld = '0;
    logic [N-1:0]   lst = '0;
    logic [W-1:0]   d [N];
    logic           rdy = 1'b0;
    logic [N*W-1:0] req_data;

    logic [N-1:0] o_req_ready;
    logic [W-1:0] o_tx_data;
    logic         o_tx_req;
    logic [N-1:0] o_grant;
    logic         o_busy;
    logic         o_timeout;
    logic [1:0]   o_timeout_id;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) req_data[k*W +: W] = d[k];
    end

    uart_tx_arbiter #(
        .NumReq       (N),
        .DataLength   (W),
        .TimeoutCycles(TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (vld),
        .i_req_data  (req_data),
        .i_req_last  (lst),
        .o_req_ready (o_req_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_req    (o_tx_req),
        .i_tx_rdy    (rdy),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout),
        .o_timeout_id(o_timeout_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = nobody), previous owner, consecutive stalled granted cycles.
    int   m_owner, m_last, m_stall, m_tid;
    bit   m_to;
    ent_t q [N][$];
    logic [N-1:0] acc = '0;
    int   cyc = 0, to_seen = 0, to_cyc = 0;
    int   xfer_cyc [N];

    task automatic m_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_stall = 0;
        m_tid   = 0;
        m_to    = 0;
    endtask

    task automatic step();
        logic [N-1:0] e_grant, e_rdy;
        logic         e_req;
        logic [W-1:0] e_data;
        @(negedge clk);
        cyc++;
        e_grant = '0;
        e_rdy   = '0;
        e_req   = 1'b0;
        e_data  = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_rdy[m_owner]   = rdy;
            e_req            = vld[m_owner] & rdy;
            e_data           = d[m_owner];
        end
        check_eq("grant", o_grant, e_grant);
        check_eq("busy", o_busy, m_owner >= 0);
        check_eq("ready", o_req_ready, e_rdy);
        check_eq("tx_req", o_tx_req, e_req);
        check_eq("tx_data", o_tx_data, e_data);
        check_eq("timeout", o_timeout, m_to);
        check_eq("timeout_id", o_timeout_id, m_tid);
        if (o_tx_req) for (int k = 0; k < N; k++) if (o_grant[k]) xfer_cyc[k] = cyc;
        if (o_timeout) begin
            to_seen++;
            to_cyc = cyc;
        end
        acc = vld & e_rdy;
        @(posedge clk);
        m_to = 0;
        if (m_owner < 0) begin
            for (int i = 1; i <= N; i++)
                if (m_owner < 0 && vld[(m_last + i) % N]) m_owner = (m_last + i) % N;
            m_stall = 0;
        end else if (vld[m_owner] && rdy) begin
            m_stall = 0;
            if (lst[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else begin
            m_stall++;
            if (m_stall == TO) begin
                m_to    = 1;
                m_tid   = m_owner;
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        #1;
    endtask

    // Requesters present queued bytes, holding them until accepted.
    task automatic feed();
        ent_t e;
        for (int k = 0; k < N; k++) begin
            if (vld[k] && !acc[k]) continue;
            vld[k] = 1'b0;
            lst[k] = 1'($urandom % 2);
            d[k]   = 8'($urandom);
            if (q[k].size() == 0) continue;
            if (q[k][0].gap > 0) begin
                q[k][0].gap--;
                continue;
            end
            e = q[k].pop_front();
            vld[k] = 1'b1;
            d[k]   = e.data;
            lst[k] = e.last;
        end
    endtask

    task automatic push(input int k, input int gap, input bit last, input logic [7:0] data);
        ent_t e;
        e.gap  = gap;
        e.last = last;
        e.data = data;
        q[k].push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            feed();
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            d[k] = '0;
            xfer_cyc[k] = 0;
        end
        m_reset();
        #3;
        check_eq("rst_grant", o_grant, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_tx_req", o_tx_req, 0);
        check_eq("rst_timeout_id", o_timeout_id, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        rdy = 1'b1;

        // Single requester, three-byte packet.
        push(1, 0, 0, 8'h41);
        push(1, 0, 0, 8'h42);
        push(1, 0, 1, 8'h43);
        feed();
        run(8);

        // Fairness: every requester queues two 2-byte packets.
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < N; k++) begin
                push(k, 0, 0, 8'(16 * k + 2 * p));
                push(k, 0, 1, 8'(16 * k + 2 * p + 1));
            end
        feed();
        run(30);

        // Backpressure mid-packet on requester 2.
        push(2, 0, 0, 8'hA0);
        push(2, 0, 0, 8'hA1);
        push(2, 0, 1, 8'hA2);
        feed();
        for (int i = 0; i < 14; i++) begin
            rdy = !(i >= 3 && i < 8);
            step();
            feed();
        end
        rdy = 1'b1;
        check_eq("bp_no_timeout", to_seen, 0);

        // Timeout: requester 3 abandons its packet; 0 and 1 become valid afterwards.
        push(3, 0, 0, 8'h55);
        push(0, 25, 1, 8'h60);
        push(1, 25, 1, 8'h61);
        feed();
        run(40);
        check_eq("to_count", to_seen, 1);
        check_eq("to_delay", to_cyc - xfer_cyc[3], TO + 1);

        // Last byte lands on the final stall cycle before timeout: normal release.
        push(2, 0, 0, 8'hC0);
        push(2, TO - 1, 1, 8'hC1);
        feed();
        run(TO + 8);
        check_eq("edge_no_timeout", to_seen, 1);

        // Asynchronous reset during the second byte of a 4-byte packet.
        for (int b = 0; b < 4; b++) push(1, 0, b == 3, 8'(8'hD0 + b));
        feed();
        run(2);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_grant", o_grant, 0);
        check_eq("arst_busy", o_busy, 0);
        check_eq("arst_tx_req", o_tx_req, 0);
        check_eq("arst_ready", o_req_ready, 0);
        check_eq("arst_tx_data", o_tx_data, 0);
        check_eq("arst_timeout", o_timeout, 0);
        for (int k = 0; k < N; k++) q[k].delete();
        m_reset();
        acc = '0;
        vld = 4'b1001;
        lst = 4'b1001;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        run(8);

        // Random traffic with backpressure, gaps and occasional long stalls.
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < N; k++) begin
                if (q[k].size() == 0 && $urandom % 4 == 0) begin
                    int len;
                    len = 1 + int'($urandom % 4);
                    for (int b = 0; b < len; b++) begin
                        int gap;
                        case ($urandom % 16)
                            0:       gap = 10 + int'($urandom % 12);
                            1, 2, 3: gap = int'($urandom % 3);
                            default: gap = 0;
                        endcase
                        push(k, gap, b == len - 1, 8'($urandom));
                    end
                end
            end
            rdy = ($urandom % 6) != 0;
            step();
            feed();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
